// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR AXI4-Lite transfer engine.
package dfr_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RAM_RD,
      RAM_WAIT,
      WR_XFER,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RAM_WR,
      FINISH
   } dfr_axi_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         WORD_BYTES      = 4;

endpackage

// File: rtl/dfr_axi_master.sv
// AXI4-Lite initiator moving word_count words between the local single-port ram and system memory.
// Optional per-phase watchdog is enabled with `define DFR_AXI_MASTER_TIMEOUT_EN.
module dfr_axi_master
   import dfr_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int RAM_ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              dir,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
   input  logic [RAM_ADDR_WIDTH:0]           word_count,
   output logic                              busy,
   output logic                              done,
   output logic                              err,
   output dfr_axi_state_t                    fsm_state,
   output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
   output logic                              ram_wen,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     ram_din,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     ram_dout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int IDX_W = RAM_ADDR_WIDTH + 1;

   // Handshake rule: every VALID stays high until the cycle its READY is seen, then drops;
   // the engine's READY outputs are raised only in the state that waits for the matching VALID.

   if (C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("dfr_axi_master: data width must be 32 and TIMEOUT_CYCLES at least 1");
   end

   dfr_axi_state_t                  state;
   logic [IDX_W-1:0]                idx;
   logic [IDX_W-1:0]                idx_inc;
   logic [IDX_W-1:0]                count_r;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   base_r;
   logic                            aw_ok;
   logic                            w_ok;
   logic                            tmo_hit;

   function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr(
      input logic [C_M_AXI_ADDR_WIDTH-1:0] base,
      input logic [IDX_W-1:0]              i
   );
      return base + C_M_AXI_ADDR_WIDTH'(i) * C_M_AXI_ADDR_WIDTH'(WORD_BYTES);
   endfunction

   assign idx_inc     = idx + IDX_W'(1);
   assign aw_ok       = !M_AXI_AWVALID || M_AXI_AWREADY;
   assign w_ok        = !M_AXI_WVALID || M_AXI_WREADY;
   assign fsm_state   = state;
   assign M_AXI_WSTRB = '1;

`ifdef DFR_AXI_MASTER_TIMEOUT_EN
   localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             in_phase;
   logic             phase_step;

   assign in_phase   = (state == WR_XFER) || (state == WR_RESP) ||
                       (state == RD_ADDR) || (state == RD_DATA);
   // Moving between two waiting phases restarts the count for the new phase.
   assign phase_step = ((state == WR_XFER) && aw_ok && w_ok) ||
                       ((state == RD_ADDR) && M_AXI_ARREADY);
   assign tmo_hit    = in_phase && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst || !in_phase || phase_step || tmo_hit) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + TMO_W'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         idx           <= '0;
         count_r       <= '0;
         base_r        <= '0;
         ram_addr      <= '0;
         ram_wen       <= 1'b0;
         ram_din       <= '0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         done    <= 1'b0;
         ram_wen <= 1'b0;
         if (tmo_hit) begin
            // Abandoning the slave is the one case where VALID drops without READY.
            err           <= 1'b1;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            state         <= FINISH;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     base_r  <= base_addr;
                     count_r <= word_count;
                     idx     <= '0;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     if (word_count == '0) begin
                        state <= FINISH;
                     end else if (dir) begin
                        M_AXI_ARADDR  <= word_addr(base_addr, '0);
                        M_AXI_ARVALID <= 1'b1;
                        state         <= RD_ADDR;
                     end else begin
                        ram_addr <= '0;
                        state    <= RAM_RD;
                     end
                  end
               end
               RAM_RD: state <= RAM_WAIT;
               RAM_WAIT: begin
                  M_AXI_WDATA   <= ram_dout;
                  M_AXI_AWADDR  <= word_addr(base_r, idx);
                  M_AXI_AWVALID <= 1'b1;
                  M_AXI_WVALID  <= 1'b1;
                  state         <= WR_XFER;
               end
               WR_XFER: begin
                  if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                  if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                  if (aw_ok && w_ok) begin
                     M_AXI_BREADY <= 1'b1;
                     state        <= WR_RESP;
                  end
               end
               WR_RESP: begin
                  if (M_AXI_BVALID) begin
                     M_AXI_BREADY <= 1'b0;
                     if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                        err   <= 1'b1;
                        state <= FINISH;
                     end else begin
                        idx <= idx_inc;
                        if (idx_inc == count_r) begin
                           state <= FINISH;
                        end else begin
                           ram_addr <= idx_inc[RAM_ADDR_WIDTH-1:0];
                           state    <= RAM_RD;
                        end
                     end
                  end
               end
               RD_ADDR: begin
                  if (M_AXI_ARREADY) begin
                     M_AXI_ARVALID <= 1'b0;
                     M_AXI_RREADY  <= 1'b1;
                     state         <= RD_DATA;
                  end
               end
               RD_DATA: begin
                  if (M_AXI_RVALID) begin
                     M_AXI_RREADY <= 1'b0;
                     if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                        err   <= 1'b1;
                        state <= FINISH;
                     end else begin
                        ram_addr <= idx[RAM_ADDR_WIDTH-1:0];
                        ram_din  <= M_AXI_RDATA;
                        ram_wen  <= 1'b1;
                        state    <= RAM_WR;
                     end
                  end
               end
               RAM_WR: begin
                  idx <= idx_inc;
                  if (idx_inc == count_r) begin
                     state <= FINISH;
                  end else begin
                     M_AXI_ARADDR  <= word_addr(base_r, idx_inc);
                     M_AXI_ARVALID <= 1'b1;
                     state         <= RD_ADDR;
                  end
               end
               FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dfr_axi_master.sv
// Directed bench for dfr_axi_master: ram model, AXI4-Lite slave model, write scoreboard.
module tb_dfr_axi_master;
   import dfr_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 dir;
   logic [31:0]          base_addr;
   logic [14:0]          word_count;
   logic                 busy;
   logic                 done;
   logic                 err;
   dfr_axi_state_t       fsm_state;
   logic [13:0]          ram_addr;
   logic                 ram_wen;
   logic [31:0]          ram_din;
   logic [31:0]          ram_dout;
   logic [31:0]          awaddr;
   logic                 awvalid;
   logic                 awready;
   logic [31:0]          wdata;
   logic [3:0]           wstrb;
   logic                 wvalid;
   logic                 wready;
   logic [1:0]           bresp;
   logic                 bvalid;
   logic                 bready;
   logic [31:0]          araddr;
   logic                 arvalid;
   logic                 arready;
   logic [31:0]          rdata;
   logic [1:0]           rresp;
   logic                 rvalid;
   logic                 rready;

   dfr_axi_master #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .RAM_ADDR_WIDTH     (14),
      .TIMEOUT_CYCLES     (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .dir           (dir),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .fsm_state     (fsm_state),
      .ram_addr      (ram_addr),
      .ram_wen       (ram_wen),
      .ram_din       (ram_din),
      .ram_dout      (ram_dout),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- counters and scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_aw_q[$];
   logic [31:0] aw_log[$];
   logic [31:0] w_log[$];
   logic [31:0] ar_log[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- local ram model ----------------
   logic [31:0] mem [0:16383];
   logic        load_en;
   logic [13:0] load_addr;
   logic [31:0] load_data;

   always @(posedge clk) begin
      if (load_en)      mem[load_addr] <= load_data;
      else if (ram_wen) mem[ram_addr]  <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // ---------------- AXI4-Lite slave model (drives on negedge) ----------------
   logic [31:0] rd_tab[$];
   int  aw_rdy_en = 1;
   int  bad_b     = -1;
   int  ar_delay  = 0;
   int  r_never   = 0;
   int  b_cnt, r_cnt, r_owed, ar_wait;
   int  b_fired, r_fired, ar_fired, ar_pend;
   int  ar_stall, ar_drop, wen_cnt, done_cnt, valid_seen;

   always @(negedge clk) begin
      if (rst) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
         arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = AXI_RESP_OKAY;
         b_cnt = 0; r_cnt = 0; r_owed = 0; ar_wait = 0;
         b_fired = 0; r_fired = 0; ar_fired = 0; ar_pend = 0;
      end else begin
         // responses first so they start one cycle after the address/data handshake
         if (b_fired != 0) begin
            bvalid = 1'b0; b_fired = 0;
         end else if (!bvalid && aw_log.size() > b_cnt && w_log.size() > b_cnt) begin
            bvalid = 1'b1;
            bresp  = (b_cnt == bad_b) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         if (bvalid && bready) begin b_fired = 1; b_cnt++; end

         if (r_fired != 0) begin
            rvalid = 1'b0; r_fired = 0;
         end else if (!rvalid && r_owed > 0 && r_never == 0) begin
            rvalid = 1'b1;
            rdata  = (r_cnt < rd_tab.size()) ? rd_tab[r_cnt] : 32'hBAD0_BAD0;
            rresp  = AXI_RESP_OKAY;
         end
         if (rvalid && rready) begin r_fired = 1; r_cnt++; r_owed--; end

         awready = (aw_rdy_en != 0);
         wready  = (aw_rdy_en != 0);
         if (awvalid && awready) aw_log.push_back(awaddr);
         if (wvalid && wready)   w_log.push_back(wdata);

         if (ar_pend != 0 && !arvalid) ar_drop++;
         if (ar_fired != 0) begin
            arready = 1'b0; ar_fired = 0; ar_wait = 0;
         end else if (arvalid) begin
            if (ar_wait >= ar_delay) arready = 1'b1;
            else                     ar_wait++;
         end
         if (arvalid && !arready) ar_stall++;
         if (arvalid && arready) begin
            ar_fired = 1;
            ar_log.push_back(araddr);
            r_owed++;
         end
         ar_pend = (arvalid && !arready) ? 1 : 0;
      end
      if (awvalid || wvalid || arvalid) valid_seen = 1;
      if (ram_wen) wen_cnt++;
      if (done)    done_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_sb();
      @(posedge clk);
      exp_q.delete(); exp_aw_q.delete(); aw_log.delete(); w_log.delete(); ar_log.delete();
      b_cnt = 0; r_cnt = 0; r_owed = 0;
      ar_stall = 0; ar_drop = 0; wen_cnt = 0; done_cnt = 0; valid_seen = 0;
      bad_b = -1; ar_delay = 0; r_never = 0; aw_rdy_en = 1;
      rd_tab.delete();
   endtask

   task automatic load_word(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic start_xfer(input logic d, input logic [31:0] base, input logic [14:0] cnt);
      @(negedge clk);
      dir = d; base_addr = base; word_count = cnt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the first negedge after the start cycle; that cycle counts as 1.
   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (!done && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_aw_n"}, aw_log.size(), exp_aw_q.size());
      check({tag, "_w_n"}, w_log.size(), exp_q.size());
      while (aw_log.size() > 0 && exp_aw_q.size() > 0)
         check({tag, "_awaddr"}, aw_log.pop_front(), exp_aw_q.pop_front());
      while (w_log.size() > 0 && exp_q.size() > 0)
         check({tag, "_wdata"}, w_log.pop_front(), exp_q.pop_front());
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int lat;
      int rd_cyc;
      rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; word_count = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      ar_stall = 0; ar_drop = 0; wen_cnt = 0; done_cnt = 0; valid_seen = 0;
      repeat (3) @(negedge clk);
      check("rst_state", 64'(fsm_state), 64'(IDLE));
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, ram_wen}, 0);
      check("rst_ram_addr", ram_addr, 0);
      rst = 1'b0;

      // 1: three-word write, zero-wait slave
      clear_sb();
      load_word(0, 32'hAAAA_0001);
      load_word(1, 32'hBBBB_0002);
      load_word(2, 32'hCCCC_0003);
      exp_aw_q = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
      exp_q    = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      start_xfer(1'b0, 32'h1000_0000, 15'd3);
      check("t1_busy", busy, 1);
      wait_done(100, lat);
      check("t1_latency", lat, 14);
      check("t1_err", err, 0);
      check("t1_wstrb", wstrb, 4'hF);
      compare_writes("t1");

      // 2: two-word read with slow ARREADY; a second start while busy is ignored
      clear_sb();
      load_word(0, 32'hDEAD_BEEF);
      load_word(1, 32'hDEAD_BEEF);
      rd_tab   = '{32'h0000_0011, 32'h0000_0022};
      ar_delay = 5;
      start_xfer(1'b1, 32'h2000_0040, 15'd2);
      start_xfer(1'b0, 32'h3000_0000, 15'd5);
      wait_done(200, lat);
      @(negedge clk);
      check("t2_err", err, 0);
      check("t2_ram0", mem[0], 32'h0000_0011);
      check("t2_ram1", mem[1], 32'h0000_0022);
      check("t2_ar_n", ar_log.size(), 2);
      if (ar_log.size() == 2) begin
         check("t2_araddr0", ar_log[0], 32'h2000_0040);
         check("t2_araddr1", ar_log[1], 32'h2000_0044);
      end
      check("t2_ar_stall", ar_stall, 10);
      check("t2_ar_drop", ar_drop, 0);
      check("t2_wen_cnt", wen_cnt, 2);
      check("t2_no_aw", aw_log.size(), 0);
      check("t2_done_cnt", done_cnt, 1);

      // 3: four-word write, SLVERR on word 1 stops the transfer
      clear_sb();
      load_word(0, 32'h3000_0000);
      load_word(1, 32'h3111_1111);
      load_word(2, 32'h3222_2222);
      load_word(3, 32'h3333_3333);
      bad_b    = 1;
      exp_aw_q = '{32'h0000_0100, 32'h0000_0104};
      exp_q    = '{32'h3000_0000, 32'h3111_1111};
      start_xfer(1'b0, 32'h0000_0100, 15'd4);
      wait_done(200, lat);
      check("t3_err", err, 1);
      @(negedge clk);
      check("t3_busy_after", busy, 0);
      check("t3_done_pulse", done, 0);
      check("t3_err_sticky", err, 1);
      check("t3_done_cnt", done_cnt, 1);
      compare_writes("t3");

      // 4: zero-length transfer clears err and produces no AXI traffic
      clear_sb();
      start_xfer(1'b0, 32'h4000_0000, 15'd0);
      check("t4_busy", busy, 1);
      wait_done(20, lat);
      check("t4_latency", lat, 2);
      check("t4_err_cleared", err, 0);
      check("t4_busy_at_done", busy, 0);
      check("t4_no_valid", valid_seen, 0);

      // 7: address wraps past the top of the address space
      clear_sb();
      exp_aw_q = '{32'hFFFF_FFFC, 32'h0000_0000};
      exp_q    = '{32'h3000_0000, 32'h3111_1111};
      start_xfer(1'b0, 32'hFFFF_FFFC, 15'd2);
      wait_done(100, lat);
      check("t7_latency", lat, 10);
      compare_writes("t7");

      // 5: reset in the middle of WR_XFER with AWVALID pending
      clear_sb();
      aw_rdy_en = 0;
      start_xfer(1'b0, 32'h5000_0000, 15'd1);
      for (int i = 0; i < 20 && fsm_state != WR_XFER; i++) @(negedge clk);
      check("t5_in_wr_xfer", 64'(fsm_state), 64'(WR_XFER));
      check("t5_awvalid", awvalid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_state", 64'(fsm_state), 64'(IDLE));
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_err", err, 0);
      check("t5_valids", {awvalid, wvalid, arvalid, bready, rready, ram_wen}, 0);
      check("t5_ram_addr", ram_addr, 0);
      rst = 1'b0;
      aw_rdy_en = 1;

`ifdef DFR_AXI_MASTER_TIMEOUT_EN
      // 6: slave never returns read data; watchdog fires after 16 RD_DATA cycles
      clear_sb();
      r_never = 1;
      rd_cyc  = 0;
      start_xfer(1'b1, 32'h6000_0000, 15'd1);
      for (int i = 0; i < 100 && !done; i++) begin
         if (fsm_state == RD_DATA) rd_cyc++;
         @(negedge clk);
      end
      check("t6_done", done, 1);
      check("t6_rd_cycles", rd_cyc, 16);
      check("t6_err", err, 1);
      check("t6_rready", rready, 0);
      check("t6_no_ram_write", wen_cnt, 0);
      r_never = 0;
`else
      rd_cyc = 0;
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
